// File: rtl/servo_pkg.sv
// servo_pkg -- shared definitions for the servo slew controller and the
// downstream PWM generator.
//   servo_state_e : slew controller FSM states
//   FRAME_TICKS   : clk cycles per 20 ms frame at 24 MHz
//   STEP_DEG      : largest angle change per frame, in degrees
//   SAFE_ANGLE    : angle forced while the emergency stop is active
//   MAX_ANGLE     : ceiling applied to requested targets
//   MIN_PULSE     : pulse high time at 0 degrees, in clk ticks
//   TICKS_PER_DEG : additional pulse high time per degree, in clk ticks
//   clamp_angle() : limit a requested angle to a ceiling
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        ESTOP_HOLD
    } servo_state_e;

    localparam int unsigned FRAME_TICKS   = 480000;
    localparam int unsigned STEP_DEG      = 5;
    localparam int unsigned SAFE_ANGLE    = 30;
    localparam int unsigned MAX_ANGLE     = 180;
    localparam int unsigned MIN_PULSE     = 12000;
    localparam int unsigned TICKS_PER_DEG = 267;

    function automatic logic [7:0] clamp_angle(input logic [7:0] angle,
                                               input logic [7:0] ceiling);
        return (angle > ceiling) ? ceiling : angle;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer -- free-running frame counter, 0 .. FRAME_TICKS-1 then wrap.
//   clk        : system clock
//   reset      : asynchronous, active-high; counter restarts from 0
//   frame_tick : high for exactly the cycle in which the count is FRAME_TICKS-1
module frame_timer #(
    parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
    input  logic clk,
    input  logic reset,
    output logic frame_tick
);

    localparam int unsigned CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tick_q;

    assign count_d = (count_q == LAST) ? '0 : count_q + CW'(1);

    // NOTE: every register gets an explicit value in the asynchronous reset
    // branch so the block comes out of reset in a known state without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            // Registered decode of the next count: high while count == LAST.
            tick_q  <= (count_d == LAST);
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/servo_slew.sv
// servo_slew -- slew-rate limited servo angle controller with emergency stop.
//   clk          : system clock
//   reset        : asynchronous, active-high
//   target_angle : requested angle in degrees (clamped to MAX_ANGLE)
//   target_valid : one-cycle strobe latching target_angle
//   estop        : level emergency stop, already synchronised to clk
//   cur_angle    : present commanded angle
//   pulse_width  : PWM high time in clk ticks, MIN_PULSE + cur_angle*TICKS_PER_DEG
//   frame_tick   : one-cycle pulse at each frame boundary
//   moving       : cur_angle differs from the latched target
//   at_target    : cur_angle equals the target and estop is not holding
module servo_slew
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_TICKS   = servo_pkg::FRAME_TICKS,
    parameter int unsigned STEP_DEG      = servo_pkg::STEP_DEG,
    parameter int unsigned SAFE_ANGLE    = servo_pkg::SAFE_ANGLE,
    parameter int unsigned MAX_ANGLE     = servo_pkg::MAX_ANGLE,
    parameter int unsigned MIN_PULSE     = servo_pkg::MIN_PULSE,
    parameter int unsigned TICKS_PER_DEG = servo_pkg::TICKS_PER_DEG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  target_angle,
    input  logic        target_valid,
    input  logic        estop,
    output logic [7:0]  cur_angle,
    output logic [15:0] pulse_width,
    output logic        frame_tick,
    output logic        moving,
    output logic        at_target
);

    localparam logic [7:0]  SAFE8       = 8'(SAFE_ANGLE);
    localparam logic [7:0]  MAX8        = 8'(MAX_ANGLE);
    localparam logic [7:0]  STEP8       = 8'(STEP_DEG);
    localparam logic [8:0]  STEP9       = 9'(STEP_DEG);
    localparam logic [15:0] RESET_PULSE = 16'(MIN_PULSE + SAFE_ANGLE * TICKS_PER_DEG);

    servo_state_e state_q, state_d;
    logic [7:0]   cur_q, cur_d;
    logic [7:0]   target_q, target_d;
    logic [15:0]  pulse_q;
    logic         moving_q;
    logic         at_target_q;

    logic [8:0]   up_sum;
    logic [8:0]   down_limit;
    logic [7:0]   step_up;
    logic [7:0]   step_down;
    logic [15:0]  pulse_calc;

    frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick)
    );

    // 9-bit step arithmetic: a step that would pass the target lands on it,
    // so neither direction can overshoot or wrap below zero.
    assign up_sum     = {1'b0, cur_q} + STEP9;
    assign down_limit = {1'b0, target_q} + STEP9;
    assign step_up    = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
    assign step_down  = ({1'b0, cur_q} <= down_limit) ? target_q : cur_q - STEP8;

    assign pulse_calc = 16'(MIN_PULSE) + 16'(cur_q) * 16'(TICKS_PER_DEG);

    // NOTE: every signal assigned here starts from a default so no path can
    // leave it unassigned and infer a latch; combinational logic uses blocking
    // assignments, the register block below uses non-blocking ones.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;

        if (estop) begin
            // Estop wins over any strobe or frame boundary in the same cycle.
            state_d  = ESTOP_HOLD;
            cur_d    = SAFE8;
            target_d = SAFE8;
        end else begin
            case (state_q)
                ESTOP_HOLD: begin
                    // Strobes are ignored on the way out of the hold.
                    state_d  = IDLE;
                    target_d = SAFE8;
                end
                IDLE: begin
                    if (target_q > cur_q) begin
                        state_d = RAMP_UP;
                    end else if (target_q < cur_q) begin
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (cur_q == target_q) begin
                        state_d = IDLE;
                    end else if (frame_tick) begin
                        // Direction follows the latest target at each boundary.
                        if (target_q > cur_q) begin
                            state_d = RAMP_UP;
                            cur_d   = step_up;
                        end else begin
                            state_d = RAMP_DOWN;
                            cur_d   = step_down;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (target_valid && (state_q != ESTOP_HOLD)) begin
                target_d = clamp_angle(target_angle, MAX8);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= SAFE8;
            target_q    <= SAFE8;
            pulse_q     <= RESET_PULSE;
            moving_q    <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            pulse_q     <= pulse_calc;
            // Status flags are registered from next-state values so they line
            // up with cur_angle and can never both be high.
            moving_q    <= (cur_d != target_d);
            at_target_q <= (cur_d == target_d) && (state_d != ESTOP_HOLD);
        end
    end

    assign cur_angle   = cur_q;
    assign pulse_width = pulse_q;
    assign moving      = moving_q;
    assign at_target   = at_target_q;

endmodule

// File: tb/tb_servo_slew.sv
// Self-checking bench for servo_slew with a short frame for simulation speed.
module tb_servo_slew;

    localparam int FT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  target_angle;
    logic        target_valid;
    logic        estop;
    logic [7:0]  cur_angle;
    logic [15:0] pulse_width;
    logic        frame_tick;
    logic        moving;
    logic        at_target;

    always #5 clk = ~clk;

    servo_slew #(
        .FRAME_TICKS (FT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target_angle (target_angle),
        .target_valid (target_valid),
        .estop        (estop),
        .cur_angle    (cur_angle),
        .pulse_width  (pulse_width),
        .frame_tick   (frame_tick),
        .moving       (moving),
        .at_target    (at_target)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // Behavioural reference: angle moves toward the target by at most 5 degrees
    // on a frame boundary, but only once the difference has been seen for a cycle.
    int m_cnt, m_cur, m_tgt, m_pw;
    bit m_tick, m_hold, m_active;

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_cur = 30; m_tgt = 30;
        m_pw = 12000 + 30 * 267; m_hold = 0; m_active = 0;
    endtask

    task automatic model_edge();
        int old_cur = m_cur;
        int old_tgt = m_tgt;
        bit old_tick = m_tick;
        m_pw = 12000 + old_cur * 267;
        if (estop) begin
            m_hold = 1; m_cur = 30; m_tgt = 30; m_active = 0;
        end else if (m_hold) begin
            m_hold = 0; m_tgt = 30; m_active = 0;
        end else begin
            if (m_active && old_tick && old_cur != old_tgt) begin
                if (old_tgt > old_cur) m_cur = (old_tgt - old_cur > 5) ? old_cur + 5 : old_tgt;
                else                   m_cur = (old_cur - old_tgt > 5) ? old_cur - 5 : old_tgt;
            end
            if (target_valid) m_tgt = (int'(target_angle) > 180) ? 180 : int'(target_angle);
            m_active = (old_cur != old_tgt);
        end
        m_cnt  = (m_cnt + 1) % FT;
        m_tick = (m_cnt == FT - 1);
    endtask

    task automatic check_model();
        check("model_cur", cur_angle, m_cur);
        check("model_pulse", pulse_width, m_pw);
        check("model_tick", frame_tick, m_tick);
        check("model_moving", moving, (m_cur != m_tgt));
        check("model_at_target", at_target, (m_cur == m_tgt) && !m_hold);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cur"}, cur_angle, 30);
        check({tag, "_pulse"}, pulse_width, 20010);
        check({tag, "_at_target"}, at_target, 1);
        check({tag, "_moving"}, moving, 0);
        check({tag, "_tick"}, frame_tick, 0);
    endtask

    // Asserts reset between edges, checks outputs before any edge, releases.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        target_valid = 1'b0;
        estop = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic tick_timing(input string tag);
        int first = -1;
        int second = -1;
        for (int n = 1; n <= 2 * FT + 2; n++) begin
            cycle();
            if (frame_tick === 1'b1) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        check({tag, "_first_tick"}, first, FT - 1);
        check({tag, "_second_tick"}, second, 2 * FT - 1);
    endtask

    task automatic strobe(input int angle);
        target_angle = 8'(angle);
        target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
    endtask

    task automatic run_until_cur(input int val, input string name);
        int i = 0;
        while (m_cur != val && i < 50 * FT) begin
            cycle();
            i++;
        end
        if (m_cur != val) timeout(name);
    endtask

    task automatic settle(input string name);
        int i = 0;
        while (!(m_cur == m_tgt && !m_active) && i < 50 * FT) begin
            cycle();
            i++;
        end
        if (!(m_cur == m_tgt && !m_active)) timeout(name);
        cycle();
    endtask

    typedef struct {
        int req;
        int exp_cur;
        int exp_pulse;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int prev, steps, mv_bad, last_from, expv;
        bit first_change;

        vecs[0] = '{150, 150, 52050};
        vecs[1] = '{200, 180, 60060};
        vecs[2] = '{32, 32, 20544};
        vecs[3] = '{0, 0, 12000};
        vecs[4] = '{181, 180, 60060};
        vecs[5] = '{255, 180, 60060};
        vecs[6] = '{90, 90, 36030};
        vecs[7] = '{30, 30, 20010};

        reset = 1'b1;
        target_angle = 8'd0;
        target_valid = 1'b0;
        estop = 1'b0;
        model_reset();

        // Reset release and frame timing.
        do_reset("por");
        tick_timing("por");

        // Ramp from 30 to 150 in 24 frames.
        do_reset("r150");
        strobe(150);
        prev = 30; steps = 0; mv_bad = 0;
        for (int i = 0; i < 30 * FT && prev != 150; i++) begin
            cycle();
            if (int'(cur_angle) != prev) begin
                expv = (prev + 5 > 150) ? 150 : prev + 5;
                check("ramp150_step", cur_angle, expv);
                prev = int'(cur_angle);
                steps++;
            end
            if (prev != 150 && moving !== 1'b1) mv_bad++;
        end
        check("ramp150_steps", steps, 24);
        check("ramp150_moving_low", mv_bad, 0);
        cycle();
        cycle();
        check("ramp150_at_target", at_target, 1);
        check("ramp150_moving", moving, 0);
        check("ramp150_pulse", pulse_width, 52050);

        // Reversal mid-ramp: 150 replaced by 32 at cur=60.
        do_reset("rev");
        strobe(150);
        run_until_cur(60, "rev_reach60");
        strobe(32);
        prev = 60; last_from = 0; first_change = 1;
        for (int i = 0; i < 20 * FT && prev != 32; i++) begin
            cycle();
            if (int'(cur_angle) != prev) begin
                expv = (prev - 5 < 32) ? 32 : prev - 5;
                check(first_change ? "rev_first_step" : "rev_step", cur_angle, expv);
                first_change = 0;
                last_from = prev;
                prev = int'(cur_angle);
            end
        end
        check("rev_final", cur_angle, 32);
        check("rev_last_from", last_from, 35);

        // Table of targets, each settled from wherever the previous left off.
        do_reset("tbl");
        foreach (vecs[k]) begin
            strobe(vecs[k].req);
            settle("tbl_settle");
            check("tbl_cur", cur_angle, vecs[k].exp_cur);
            check("tbl_pulse", pulse_width, vecs[k].exp_pulse);
            check("tbl_at_target", at_target, 1);
        end

        // Estop together with a strobe at cur=90.
        do_reset("est");
        strobe(150);
        run_until_cur(90, "est_reach90");
        estop = 1'b1;
        target_angle = 8'd100;
        target_valid = 1'b1;
        cycle();
        check("est_cur", cur_angle, 30);
        check("est_at_target", at_target, 0);
        check("est_moving", moving, 0);
        target_angle = 8'd170;
        repeat (5) cycle();
        check("est_hold_cur", cur_angle, 30);
        estop = 1'b0;
        cycle();
        target_valid = 1'b0;
        check("est_release_cur", cur_angle, 30);
        check("est_release_at_target", at_target, 1);
        repeat (3 * FT) cycle();
        check("est_idle_cur", cur_angle, 30);
        check("est_idle_moving", moving, 0);

        // Asynchronous reset in the middle of a ramp.
        do_reset("pre_mid");
        strobe(150);
        run_until_cur(70, "mid_reach70");
        do_reset("mid");
        tick_timing("mid");

        // Randomised traffic against the reference model.
        do_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            target_valid = ($urandom_range(0, 15) == 0);
            target_angle = 8'($urandom_range(0, 255));
            if (estop) estop = ($urandom_range(0, 7) != 0);
            else       estop = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
